// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus issue FSM feeding an async UART transmitter's
// start/data/busy handshake. Define UART_TX_QUEUE_OVF_CNT_EN to build the
// saturating dropped-push counter on ovf_cnt_o (tied to 0 otherwise).
module uart_tx_queue #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_valid_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  push_ready_o,
    input  logic                  flush_i,
    output logic                  txd_start_o,
    output logic [DATA_WIDTH-1:0] txd_data_o,
    input  logic                  txd_busy_i,
    output logic [LVL_W-1:0]      level_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  idle_o,
    output logic [15:0]           ovf_cnt_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [LVL_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_e                state_q, state_d;
    logic                  start_q, start_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            wb_cnt_q, wb_cnt_d;
    logic                  push, issue;

    assign empty_o      = wr_ptr_q == rd_ptr_q;
    assign full_o       = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign level_o      = wr_ptr_q - rd_ptr_q;
    assign push_ready_o = ~full_o;
    assign idle_o       = empty_o & (state_q == IDLE);
    assign txd_start_o  = start_q;
    assign txd_data_o   = data_q;
    assign push         = push_valid_i & push_ready_o & ~flush_i;

    // Issue FSM: pop one byte when the line is free, pulse start, then track busy
    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        data_d   = data_q;
        wb_cnt_d = wb_cnt_q;
        issue    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_o && !txd_busy_i && !flush_i) begin
                    issue   = 1'b1;
                    start_d = 1'b1;
                    data_d  = mem_q[rd_ptr_q[AW-1:0]];
                    state_d = START;
                end
            end
            START: begin
                wb_cnt_d = 2'd0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (txd_busy_i) state_d = WAIT_DONE;
                else if (wb_cnt_q == 2'd3) state_d = IDLE;
                else wb_cnt_d = wb_cnt_q + 2'd1;
            end
            WAIT_DONE: begin
                if (!txd_busy_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer update; flush drops everything queued and overrides push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q + LVL_W'(push);
        rd_ptr_d = flush_i ? wr_ptr_q : rd_ptr_q + LVL_W'(issue);
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= IDLE;
            start_q  <= 1'b0;
            data_q   <= '0;
            wb_cnt_q <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            start_q  <= start_d;
            data_q   <= data_d;
            wb_cnt_q <= wb_cnt_d;
        end
    end

    // Byte storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

`ifdef UART_TX_QUEUE_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // Count pushes dropped because the queue is full, saturating at all ones
    always_comb begin
        ovf_cnt_d = (push_valid_i && full_o && !flush_i && ovf_cnt_q != 16'hFFFF) ? ovf_cnt_q + 16'd1 : ovf_cnt_q;
    end

    // Overflow counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ovf_cnt_q <= 16'd0;
        else ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_cnt_o = ovf_cnt_q;
`else
    assign ovf_cnt_o = 16'd0;
`endif
endmodule
